timer_multi_periph: RTL

Parametrised multi-channel successor to the single-channel timer peripheral, on the same req/gnt register bus. N_CH independent down-counters, each with:
- a per-channel prescaler
- one-shot or periodic (reload) mode
- read-clear expiry status
- counter readback

Adds a deterministic grant latency, STOP control and a combined level interrupt output. It sits on the SoC peripheral bus as a bus slave.

---
 rtl/timer_multi_periph_if.sv | 16 +
 rtl/timer_multi_periph.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi_periph_if.sv
// Request/grant register bus between a master and the multi-channel timer.
// The master holds req, addr, wdata and write_en stable until it sees gnt.
interface timer_multi_periph_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  write_en;

  modport master (output req, addr, wdata, write_en, input gnt, rdata);
  modport slave  (input req, addr, wdata, write_en, output gnt, rdata);
endinterface

// File: rtl/timer_multi_periph.sv
// N_CH prescaled down-counters with one-shot/periodic modes and read-clear expiry flags.
// Accesses use a fixed-latency req/gnt handshake; irq ORs the enabled expiry flags.
module timer_multi_periph #(
  parameter int N_CH       = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int GNT_DELAY  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  timer_multi_periph_if.slave  bus,
  output logic                 irq
);

  localparam int CHW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {HS_IDLE, HS_WAIT, HS_GRANT} hs_state_t;
  typedef enum logic [1:0] {CH_IDLE, CH_RUNNING, CH_EXPIRED} ch_state_t;

  hs_state_t             hs_state, hs_next;
  logic [2:0]            wait_cnt, wait_next;
  logic                  enter_grant, rd_fire, wr_fire;
  logic [CHW-1:0]        ch_idx;
  logic [1:0]            reg_idx;
  logic [N_CH-1:0]       sel_ch;
  logic [DATA_WIDTH-1:0] rd_val, rdata_q;
  logic                  irq_q;
  logic                  unused_wdata;

  logic [N_CH-1:0]       reload_en_q, reload_en_d;
  logic [N_CH-1:0]       irq_en_q, irq_en_d;
  logic [N_CH-1:0]       expired_q, expired_d;
  logic [N_CH-1:0]       exp_set;
  logic [7:0]            psc_q [N_CH];
  logic [7:0]            psc_d [N_CH];
  logic [7:0]            psc_cnt_q [N_CH];
  logic [7:0]            psc_cnt_d [N_CH];
  logic [CNT_WIDTH-1:0]  load_q [N_CH];
  logic [CNT_WIDTH-1:0]  load_d [N_CH];
  logic [CNT_WIDTH-1:0]  count_q [N_CH];
  logic [CNT_WIDTH-1:0]  count_d [N_CH];
  ch_state_t             ch_state_q [N_CH];
  ch_state_t             ch_state_d [N_CH];

  assign ch_idx       = bus.addr[ADDR_WIDTH-1:2];
  assign reg_idx      = bus.addr[1:0];
  assign bus.gnt      = (hs_state == HS_GRANT);
  assign bus.rdata    = rdata_q;
  assign irq          = irq_q;
  assign unused_wdata = ^bus.wdata;

  // A LOAD of zero behaves as one so a started channel always counts at least one tick.
  function automatic logic [CNT_WIDTH-1:0] start_val(input logic [CNT_WIDTH-1:0] ld);
    return (ld == '0) ? CNT_WIDTH'(1) : ld;
  endfunction

  always_comb begin
    hs_next     = hs_state;
    wait_next   = wait_cnt;
    enter_grant = 1'b0;
    case (hs_state)
      HS_IDLE: begin
        if (bus.req) begin
          hs_next   = HS_WAIT;
          wait_next = 3'd0;
        end
      end
      HS_WAIT: begin
        if (!bus.req) begin
          hs_next   = HS_IDLE;
          wait_next = 3'd0;
        end else if (wait_cnt == 3'(GNT_DELAY - 1)) begin
          hs_next     = HS_GRANT;
          wait_next   = 3'd0;
          enter_grant = 1'b1;
        end else begin
          wait_next = wait_cnt + 3'd1;
        end
      end
      HS_GRANT: hs_next = HS_IDLE;
      default:  hs_next = HS_IDLE;
    endcase
  end

  // Reads take effect (capture and status clear) on the edge entering grant; writes on the edge leaving it.
  assign rd_fire = enter_grant & ~bus.write_en;
  assign wr_fire = (hs_state == HS_GRANT) & bus.write_en;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sel_ch[i] = (ch_idx == CHW'(i));
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_ch[i]) begin
        case (reg_idx)
          2'd0: begin
            rd_val[15:8] = psc_q[i];
            rd_val[3]    = irq_en_q[i];
            rd_val[2]    = reload_en_q[i];
          end
          2'd1:    rd_val = DATA_WIDTH'(load_q[i]);
          2'd2:    rd_val[0] = expired_q[i];
          default: rd_val = DATA_WIDTH'(count_q[i]);
        endcase
      end
    end
  end

  // An expiry in the same cycle as a status clear keeps the flag set; STOP overrides START.
  always_comb begin
    reload_en_d = reload_en_q;
    irq_en_d    = irq_en_q;
    expired_d   = expired_q;
    exp_set     = '0;
    psc_d       = psc_q;
    psc_cnt_d   = psc_cnt_q;
    load_d      = load_q;
    count_d     = count_q;
    ch_state_d  = ch_state_q;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_state_q[i] == CH_RUNNING) begin
        if (psc_cnt_q[i] == psc_q[i]) begin
          psc_cnt_d[i] = '0;
          if (count_q[i] != '0) begin
            count_d[i] = count_q[i] - CNT_WIDTH'(1);
          end else begin
            exp_set[i]   = 1'b1;
            expired_d[i] = 1'b1;
            if (reload_en_q[i]) count_d[i] = start_val(load_q[i]);
            else                ch_state_d[i] = CH_EXPIRED;
          end
        end else begin
          psc_cnt_d[i] = psc_cnt_q[i] + 8'd1;
        end
      end
      if (rd_fire && sel_ch[i] && (reg_idx == 2'd2)) begin
        if (!exp_set[i]) expired_d[i] = 1'b0;
        if (ch_state_q[i] == CH_EXPIRED) ch_state_d[i] = CH_IDLE;
      end
      if (wr_fire && sel_ch[i]) begin
        case (reg_idx)
          2'd0: begin
            reload_en_d[i] = bus.wdata[2];
            irq_en_d[i]    = bus.wdata[3];
            psc_d[i]       = bus.wdata[15:8];
            if (bus.wdata[4] && !exp_set[i]) expired_d[i] = 1'b0;
            if (bus.wdata[1]) begin
              ch_state_d[i] = CH_IDLE;
              count_d[i]    = count_q[i];
              psc_cnt_d[i]  = psc_cnt_q[i];
            end else if (bus.wdata[0]) begin
              count_d[i]    = start_val(load_q[i]);
              psc_cnt_d[i]  = '0;
              expired_d[i]  = 1'b0;
              ch_state_d[i] = CH_RUNNING;
            end
          end
          2'd1:    load_d[i] = bus.wdata[CNT_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_state <= HS_IDLE;
      wait_cnt <= 3'd0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      hs_state <= hs_next;
      wait_cnt <= wait_next;
      rdata_q  <= rd_fire ? rd_val : '0;
      irq_q    <= |(expired_d & irq_en_d);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_en_q <= '0;
      irq_en_q    <= '0;
      expired_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        psc_q[i]      <= '0;
        psc_cnt_q[i]  <= '0;
        load_q[i]     <= '0;
        count_q[i]    <= '0;
        ch_state_q[i] <= CH_IDLE;
      end
    end else begin
      reload_en_q <= reload_en_d;
      irq_en_q    <= irq_en_d;
      expired_q   <= expired_d;
      for (int i = 0; i < N_CH; i++) begin
        psc_q[i]      <= psc_d[i];
        psc_cnt_q[i]  <= psc_cnt_d[i];
        load_q[i]     <= load_d[i];
        count_q[i]    <= count_d[i];
        ch_state_q[i] <= ch_state_d[i];
      end
    end
  end

endmodule
